// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexes one hex seven-segment decoder across
// N_DIGITS common-anode digits, with a tear-free double-buffered display value,
// a blanked lead-in at the start of every digit slot, and optional
// leading-zero blanking.
module seg_scan_controller #(
  parameter int N_DIGITS = 4,
  parameter int DWELL    = 50000,
  parameter int BLANK    = 500
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        load,
  input  logic [4*N_DIGITS-1:0]       data_in,
  input  logic                        lzb,
  output logic [3:0]                  hex_nibble,
  output logic [N_DIGITS-1:0]         an_n,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_done
);

  localparam int DW = 4 * N_DIGITS;
  localparam int IW = $clog2(N_DIGITS);
  localparam int TW = $clog2(DWELL);

  localparam logic [TW-1:0]       TICK_LAST   = TW'(DWELL - 1);
  localparam logic [TW-1:0]       DRIVE_START = TW'(BLANK);
  localparam logic [IW-1:0]       DIGIT_LAST  = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] DIGIT0_HOT  = N_DIGITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t              state;
  logic [TW-1:0]       tick;
  logic [TW-1:0]       tick_inc;
  logic [IW-1:0]       digit_next;
  logic [DW-1:0]       active;
  logic [DW-1:0]       pending;
  logic [DW-1:0]       active_next;
  logic                pending_valid;
  logic                scanning;
  logic                slot_end;
  logic                wrap;
  logic                all_zero;
  logic                suppress;
  logic [N_DIGITS-1:0] zero_from;

  // Slot and frame boundary decode, plus the value the active buffer takes at this edge
  always_comb begin
    scanning    = (state != ST_IDLE);
    slot_end    = scanning && (tick == TICK_LAST);
    wrap        = slot_end && (digit_idx == DIGIT_LAST);
    tick_inc    = tick + 1'b1;
    digit_next  = (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
    active_next = active;
    if (wrap) begin
      if (load) begin
        active_next = data_in;
      end else if (pending_valid) begin
        active_next = pending;
      end
    end
  end

  // Leading-zero detection: zero_from[i] means nibbles i..N-1 of the active value are all zero
  always_comb begin
    zero_from = '0;
    all_zero  = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero && (active[4*i +: 4] == 4'h0);
      zero_from[i] = all_zero;
    end
    suppress = lzb && (digit_idx != '0) && zero_from[digit_idx];
  end

  // Double buffer: writes land in pending and only move to active on a frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else if (wrap) begin
      active        <= active_next;
      pending_valid <= 1'b0;
    end else if (load) begin
      pending       <= data_in;
      pending_valid <= 1'b1;
    end
  end

  // Scan FSM: blank lead-in then drive for each slot, with registered decoder and anode outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tick       <= '0;
      digit_idx  <= '0;
      hex_nibble <= 4'h0;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        state     <= ST_IDLE;
        tick      <= '0;
        digit_idx <= '0;
        an_n      <= '1;
      end else if (state == ST_IDLE) begin
        state      <= ST_BLANK;
        tick       <= '0;
        digit_idx  <= '0;
        an_n       <= '1;
        hex_nibble <= active_next[3:0];
      end else if (slot_end) begin
        state      <= ST_BLANK;
        tick       <= '0;
        digit_idx  <= digit_next;
        an_n       <= '1;
        hex_nibble <= active_next[4*int'(digit_next) +: 4];
      end else begin
        tick <= tick_inc;
        if (tick_inc == DRIVE_START) begin
          state <= ST_DRIVE;
          an_n  <= suppress ? '1 : ~(DIGIT0_HOT << digit_idx);
        end
        if ((tick_inc == TICK_LAST) && (digit_idx == DIGIT_LAST)) begin
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule
